// File: rtl/regfile_operand_source_pkg.sv
// ---------------------------------------------------------------------------
// klp32_rf_pkg
// Shared constants and types for the KLP32 integer register file.
//   XLEN     : data width of every register and data port (n)
//   NREGS    : architectural register count, x0 included
//   AW       : register address width; 2**AW must equal NREGS
//   ZERO_REG : hard-wired zero register x0
// ---------------------------------------------------------------------------
package klp32_rf_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xlen_t;

    localparam reg_addr_t ZERO_REG = reg_addr_t'(0);

    // True when a write to this address actually updates architectural state.
    function automatic logic is_real_dest(input logic en, input reg_addr_t addr);
        return en && (addr != ZERO_REG);
    endfunction

endpackage

// File: rtl/regfile_operand_source_if.sv
// ---------------------------------------------------------------------------
// regfile_operand_source_if
// Bundles the operand read ports, the writeback port and the scoreboard
// signals of the register file.
//   slave  : the register file (reads addresses/writeback, drives data/stall)
//   master : the core pipeline or a testbench
// Signals: rs1_addr, rs2_addr, data1, data2, reg_write, rd_addr, rd_data,
//          pend_set, pend_rd, stall, pend_vec
// ---------------------------------------------------------------------------
interface regfile_operand_source_if;
    import klp32_rf_pkg::*;

    reg_addr_t         rs1_addr;
    reg_addr_t         rs2_addr;
    xlen_t             data1;
    xlen_t             data2;
    logic              reg_write;
    reg_addr_t         rd_addr;
    xlen_t             rd_data;
    logic              pend_set;
    reg_addr_t         pend_rd;
    logic              stall;
    logic [NREGS-1:0]  pend_vec;

    modport slave (
        input  rs1_addr, rs2_addr, reg_write, rd_addr, rd_data, pend_set, pend_rd,
        output data1, data2, stall, pend_vec
    );

    modport master (
        output rs1_addr, rs2_addr, reg_write, rd_addr, rd_data, pend_set, pend_rd,
        input  data1, data2, stall, pend_vec
    );

endinterface

// File: rtl/regfile_operand_source_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// Per-register pending (load-in-flight) bits and the operand stall decision.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   pend_set_i, pend_rd_i   : mark a destination as owed by a long-latency op
//   wr_en_i, wr_addr_i      : writeback port, clears the pending bit
//   rs1_addr_i, rs2_addr_i  : operand addresses being read this cycle
//   stall_o                 : an operand is still owed
//   pend_vec_o              : current pending bits
// Optional build macro: REGFILE_WRITE_BYPASS_EN (same-cycle writeback
// satisfies the operand, so its hit is masked).
// ---------------------------------------------------------------------------
module rf_scoreboard
    import klp32_rf_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pend_set_i,
    input  reg_addr_t        pend_rd_i,
    input  logic             wr_en_i,
    input  reg_addr_t        wr_addr_i,
    input  reg_addr_t        rs1_addr_i,
    input  reg_addr_t        rs2_addr_i,
    output logic             stall_o,
    output logic [NREGS-1:0] pend_vec_o
);

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic             hit1;
    logic             hit2;

    always_comb begin
        // NOTE: pend_d gets a full default before any conditional update so
        // every path assigns it and no latch is inferred.
        pend_d = pend_q;
        if (is_real_dest(wr_en_i, wr_addr_i)) begin
            pend_d[wr_addr_i] = 1'b0;
        end
        // Applied after the clear: a newer load to the same register wins.
        if (is_real_dest(pend_set_i, pend_rd_i)) begin
            pend_d[pend_rd_i] = 1'b1;
        end
        pend_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    // The writeback delivering the owed value this cycle satisfies the read.
    logic wr_hit1;
    logic wr_hit2;
    assign wr_hit1 = is_real_dest(wr_en_i, wr_addr_i) && (wr_addr_i == rs1_addr_i);
    assign wr_hit2 = is_real_dest(wr_en_i, wr_addr_i) && (wr_addr_i == rs2_addr_i);
    assign hit1    = pend_q[rs1_addr_i] && !wr_hit1;
    assign hit2    = pend_q[rs2_addr_i] && !wr_hit2;
`else
    // Without bypass the stored value is stale until the edge, so keep stalling.
    assign hit1 = pend_q[rs1_addr_i];
    assign hit2 = pend_q[rs2_addr_i];
`endif

    assign stall_o    = hit1 || hit2;
    assign pend_vec_o = pend_q;

endmodule

// File: rtl/regfile_operand_source.sv
// ---------------------------------------------------------------------------
// regfile_operand_source
// 32-entry KLP32 integer register file: two combinational read ports feeding
// the ALU operand muxes, one writeback port, and a pending-load scoreboard
// that raises stall while a read operand is still owed.
// Ports:
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset (clears registers and pending bits)
//   bus   : regfile_operand_source_if.slave (read, writeback, scoreboard)
// Optional build macro: REGFILE_WRITE_BYPASS_EN (write-first read of the
// register being written back in the same cycle).
// ---------------------------------------------------------------------------
module regfile_operand_source
    import klp32_rf_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    regfile_operand_source_if.slave  bus
);

    xlen_t regs_q [NREGS];
    logic  wr_en;
    xlen_t data1;
    xlen_t data2;

    assign wr_en = is_real_dest(bus.reg_write, bus.rd_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the storage array is reset because every register must read
        // 0 after reset; this makes it flops rather than an inferred RAM.
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[bus.rd_addr] <= bus.rd_data;
        end
    end

    always_comb begin
        data1 = (bus.rs1_addr == ZERO_REG) ? '0 : regs_q[bus.rs1_addr];
        data2 = (bus.rs2_addr == ZERO_REG) ? '0 : regs_q[bus.rs2_addr];
`ifdef REGFILE_WRITE_BYPASS_EN
        // wr_en already excludes x0, so x0 is never bypassed.
        if (wr_en && (bus.rd_addr == bus.rs1_addr)) begin
            data1 = bus.rd_data;
        end
        if (wr_en && (bus.rd_addr == bus.rs2_addr)) begin
            data2 = bus.rd_data;
        end
`endif
    end

    assign bus.data1 = data1;
    assign bus.data2 = data2;

    rf_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .pend_set_i (bus.pend_set),
        .pend_rd_i  (bus.pend_rd),
        .wr_en_i    (bus.reg_write),
        .wr_addr_i  (bus.rd_addr),
        .rs1_addr_i (bus.rs1_addr),
        .rs2_addr_i (bus.rs2_addr),
        .stall_o    (bus.stall),
        .pend_vec_o (bus.pend_vec)
    );

endmodule

// File: tb/tb_regfile_operand_source.sv
// ---------------------------------------------------------------------------
// tb_regfile_operand_source
// Self-checking bench for regfile_operand_source: hand-written reset
// sequence, a table of directed vectors, then randomized traffic against a
// behavioural model. Expectations follow REGFILE_WRITE_BYPASS_EN if defined.
// ---------------------------------------------------------------------------
module tb_regfile_operand_source;
    import klp32_rf_pkg::*;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    regfile_operand_source_if bus ();

    regfile_operand_source dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        reg_addr_t        rs1;
        reg_addr_t        rs2;
        logic             we;
        reg_addr_t        rd;
        xlen_t            wd;
        logic             ps;
        reg_addr_t        prd;
        xlen_t            e_d1;
        xlen_t            e_d2;
        logic             e_st;
        logic [NREGS-1:0] e_pv;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int rs1, input int rs2, input bit we, input int rd,
                                input xlen_t wd, input bit ps, input int prd,
                                input xlen_t d1, input xlen_t d2, input bit st,
                                input logic [NREGS-1:0] pv);
        vec_t v;
        v.rs1 = reg_addr_t'(rs1); v.rs2 = reg_addr_t'(rs2);
        v.we = we; v.rd = reg_addr_t'(rd); v.wd = wd;
        v.ps = ps; v.prd = reg_addr_t'(prd);
        v.e_d1 = d1; v.e_d2 = d2; v.e_st = st; v.e_pv = pv;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.rs1_addr  = v.rs1;
        bus.rs2_addr  = v.rs2;
        bus.reg_write = v.we;
        bus.rd_addr   = v.rd;
        bus.rd_data   = v.wd;
        bus.pend_set  = v.ps;
        bus.pend_rd   = v.prd;
    endtask

    // Drive one cycle of inputs, check combinational outputs mid-cycle,
    // then let the rising edge commit the cycle.
    task automatic apply(input string tag, input vec_t v);
        drive(v);
        @(negedge clk);
        check({tag, ".data1"}, bus.data1, v.e_d1);
        check({tag, ".data2"}, bus.data2, v.e_d2);
        check({tag, ".stall"}, 32'(bus.stall), 32'(v.e_st));
        check({tag, ".pend_vec"}, bus.pend_vec, v.e_pv);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, '0, 0, 0, '0, '0, 0, '0));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: architectural registers and owed registers.
    xlen_t m_r [NREGS];
    bit    m_p [NREGS];

    function automatic xlen_t m_read(input reg_addr_t rs, input vec_t v);
        if (rs == 0) return '0;
        if (BYP && v.we && v.rd == rs) return v.wd;
        return m_r[rs];
    endfunction

    function automatic bit m_owed(input reg_addr_t rs, input vec_t v);
        if (!m_p[rs]) return 1'b0;
        return !(BYP && v.we && v.rd == rs);
    endfunction

    initial begin
        vec_t v;
        rst_n = 1'b0;
        idle();
        bus.rs1_addr = 5;
        @(negedge clk);
        check("reset.data1", bus.data1, '0);
        check("reset.data2", bus.data2, '0);
        check("reset.stall", 32'(bus.stall), 0);
        check("reset.pend_vec", bus.pend_vec, '0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-run drops stored data and in-flight pending bits.
        apply("p1.wr", mk(5, 0, 1, 5, 32'hDEADBEEF, 1, 8, BYP ? 32'hDEADBEEF : 0, 0, 0, 0));
        apply("p1.rd", mk(5, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 32'h100));
        apply("p1.st", mk(8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100));
        #2;
        rst_n = 1'b0;
        drive(mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("p1.async.data1", bus.data1, '0);
        check("p1.async.stall", 32'(bus.stall), 0);
        check("p1.async.pend_vec", bus.pend_vec, '0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply("p1.post8", mk(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply("p1.post5", mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Directed table (state carries from row to row).
        tbl.push_back(mk(3, 0, 1, 3, 32'h00510193, 0, 0, BYP ? 32'h00510193 : 0, 0, 0, 0));
        tbl.push_back(mk(3, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 32'h00510193, 0, 0, 0));
        tbl.push_back(mk(3, 0, 0, 0, 0, 0, 0, 32'h00510193, 0, 0, 0));
        tbl.push_back(mk(0, 7, 0, 0, 0, 1, 7, 0, 0, 0, 0));
        tbl.push_back(mk(0, 7, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80));
        tbl.push_back(mk(0, 7, 1, 7, 32'h00200113, 0, 0, 0, BYP ? 32'h00200113 : 0, !BYP, 32'h80));
        tbl.push_back(mk(0, 7, 0, 0, 0, 0, 0, 0, 32'h00200113, 0, 0));
        tbl.push_back(mk(9, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0));
        tbl.push_back(mk(9, 0, 1, 9, 32'h11111111, 1, 9, BYP ? 32'h11111111 : 0, 0, !BYP, 32'h200));
        tbl.push_back(mk(9, 0, 0, 0, 0, 0, 0, 32'h11111111, 0, 1, 32'h200));
        tbl.push_back(mk(0, 0, 1, 9, 32'h22222222, 1, 4, 0, 0, 0, 32'h200));
        tbl.push_back(mk(4, 0, 1, 4, 32'h44444444, 1, 6, BYP ? 32'h44444444 : 0, 0, !BYP, 32'h10));
        tbl.push_back(mk(4, 6, 0, 0, 0, 0, 0, 32'h44444444, 0, 1, 32'h40));
        tbl.push_back(mk(4, 0, 0, 0, 0, 0, 0, 32'h44444444, 0, 0, 32'h40));
        tbl.push_back(mk(6, 6, 1, 6, 32'h66666666, 0, 0, BYP ? 32'h66666666 : 0,
                         BYP ? 32'h66666666 : 0, !BYP, 32'h40));
        tbl.push_back(mk(10, 10, 1, 10, 32'h00008067, 0, 0, BYP ? 32'h00008067 : 0,
                         BYP ? 32'h00008067 : 0, 0, 0));
        tbl.push_back(mk(10, 10, 0, 0, 0, 0, 0, 32'h00008067, 32'h00008067, 0, 0));
        tbl.push_back(mk(10, 9, 1, 10, 32'hAAAA5555, 0, 0, BYP ? 32'hAAAA5555 : 32'h00008067,
                         32'h22222222, 0, 0));
        tbl.push_back(mk(10, 3, 0, 0, 0, 0, 0, 32'hAAAA5555, 32'h00510193, 0, 0));
        tbl.push_back(mk(6, 7, 1, 0, 32'h12345678, 1, 0, 32'h66666666, 32'h00200113, 0, 0));

        foreach (tbl[i]) begin
            apply($sformatf("tbl%0d", i), tbl[i]);
        end

        // Randomized traffic against the model, from a fresh reset.
        pulse_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_r[i] = '0;
            m_p[i] = 1'b0;
        end
        for (int c = 0; c < 600; c++) begin
            logic [NREGS-1:0] pv;
            v.rs1 = reg_addr_t'($urandom_range(0, 11));
            v.rs2 = reg_addr_t'($urandom_range(0, 11));
            v.we  = ($urandom_range(0, 9) < 4);
            v.rd  = reg_addr_t'($urandom_range(0, 11));
            v.wd  = $urandom;
            v.ps  = ($urandom_range(0, 9) < 3);
            v.prd = reg_addr_t'($urandom_range(0, 11));
            pv = '0;
            for (int r = 0; r < NREGS; r++) pv[r] = m_p[r];
            v.e_d1 = m_read(v.rs1, v);
            v.e_d2 = m_read(v.rs2, v);
            v.e_st = m_owed(v.rs1, v) || m_owed(v.rs2, v);
            v.e_pv = pv;
            apply($sformatf("rnd%0d", c), v);
            if (v.we && v.rd != 0) begin
                m_r[v.rd] = v.wd;
                m_p[v.rd] = 1'b0;
            end
            if (v.ps && v.prd != 0) m_p[v.prd] = 1'b1;
        end

        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
